// File: rtl/fifo_rptr_empty.sv
// Read-domain pointer/status controller for a dual-clock FIFO.
// Synchronises the write Gray pointer and derives empty, almost-empty, level, underflow and read data.
module fifo_rptr_empty #(
    parameter int ADDR_WIDTH   = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                  rclk,
    input  logic                  rst_n,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   wptr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  underflow_clr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  empty,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] LP_AEMPTY = AEMPTY_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0]   r_wq1;
    logic [ADDR_WIDTH:0]   r_wq2;
    logic [ADDR_WIDTH:0]   r_rbin;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [ADDR_WIDTH:0]   r_rlevel;
    logic                  r_empty;
    logic                  r_aempty;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_underflow;

    logic                  w_rd_en;
    logic [ADDR_WIDTH:0]   w_rbin_next;
    logic [ADDR_WIDTH:0]   w_rgray_next;
    logic [ADDR_WIDTH:0]   w_wbin_sync;
    logic [ADDR_WIDTH:0]   w_level_next;

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Registered empty gates acceptance, so the edge that reads the last word also raises empty.
    assign w_rd_en      = rinc & ~r_empty;
    assign w_rbin_next  = r_rbin + {{ADDR_WIDTH{1'b0}}, w_rd_en};
    assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;
    assign w_wbin_sync  = gray2bin(r_wq2);
    assign w_level_next = w_wbin_sync - w_rbin_next;

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wq1       <= '0;
            r_wq2       <= '0;
            r_rbin      <= '0;
            r_rptr      <= '0;
            r_rlevel    <= '0;
            r_empty     <= 1'b1;
            r_aempty    <= 1'b1;
            r_rdata     <= '0;
            r_rvalid    <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wq1    <= wptr;
            r_wq2    <= r_wq1;
            r_rbin   <= w_rbin_next;
            r_rptr   <= w_rgray_next;
            r_rlevel <= w_level_next;
            r_empty  <= (w_rgray_next == r_wq2);
            r_aempty <= (w_level_next <= LP_AEMPTY);
            r_rvalid <= w_rd_en;
            if (w_rd_en) begin
                r_rdata <= mem_rdata;
            end
            // A new underflow event takes priority over a clear request.
            if (rinc && r_empty) begin
                r_underflow <= 1'b1;
            end else if (underflow_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign rptr      = r_rptr;
    assign raddr     = r_rbin[ADDR_WIDTH-1:0];
    assign empty     = r_empty;
    assign aempty    = r_aempty;
    assign rlevel    = r_rlevel;
    assign rdata     = r_rdata;
    assign rvalid    = r_rvalid;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Randomised scoreboard bench for fifo_rptr_empty against a count-based FIFO occupancy model.
module tb_fifo_rptr_empty;

    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int AEL   = 1;

    logic          rclk;
    logic          rst_n;
    logic          rinc;
    logic [AW:0]   wptr;
    logic [DW-1:0] mem_rdata;
    logic          underflow_clr;
    logic [AW:0]   rptr;
    logic [AW-1:0] raddr;
    logic          empty;
    logic          aempty;
    logic [AW:0]   rlevel;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          underflow;

    logic [DW-1:0] mem [DEPTH];
    assign mem_rdata = mem[raddr];

    fifo_rptr_empty #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AEMPTY_LEVEL(AEL)) dut (
        .rclk(rclk), .rst_n(rst_n), .rinc(rinc), .wptr(wptr), .mem_rdata(mem_rdata),
        .underflow_clr(underflow_clr), .rptr(rptr), .raddr(raddr), .empty(empty),
        .aempty(aempty), .rlevel(rlevel), .rdata(rdata), .rvalid(rvalid), .underflow(underflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int checks = 0;
    int errors = 0;

    // Occupancy model: plain write/read counts plus a two-deep visibility delay of the write count.
    int            m_wcnt, m_rcnt, m_wq1, m_wq2, m_level;
    bit            m_empty, m_aempty, m_under;
    logic [DW-1:0] m_fifo [$];
    logic [DW-1:0] exp_q  [$];
    logic [AW:0]   prev_rptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW:0] gray(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    always @(negedge rclk) begin
        if (rst_n && rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rdata_unexpected: got %0h with no read outstanding at %0t", rdata, $time);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rdata !== e) begin
                    errors++;
                    $display("FAIL rdata: got %0h expected %0h at %0t", rdata, e, $time);
                end
            end
        end
    end

    task automatic model_reset();
        m_wcnt = 0; m_rcnt = 0; m_wq1 = 0; m_wq2 = 0; m_level = 0;
        m_empty = 1; m_aempty = 1; m_under = 0;
        m_fifo.delete();
        exp_q.delete();
        prev_rptr = '0;
    endtask

    task automatic do_write(input int n);
        for (int i = 0; i < n; i++) begin
            if (m_wcnt - m_rcnt < DEPTH) begin
                logic [DW-1:0] v;
                v = DW'($urandom);
                mem[m_wcnt % DEPTH] = v;
                m_fifo.push_back(v);
                m_wcnt++;
            end
        end
        wptr = gray(m_wcnt);
    endtask

    task automatic check_status();
        chk("empty", 32'(empty), 32'(m_empty));
        chk("aempty", 32'(aempty), 32'(m_aempty));
        chk("rlevel", 32'(rlevel), 32'(m_level));
        chk("underflow", 32'(underflow), 32'(m_under));
        chk("rptr", 32'(rptr), 32'(gray(m_rcnt)));
        chk("raddr", 32'(raddr), 32'(m_rcnt % DEPTH));
        chk("rptr_onebit", 32'($countones(rptr ^ prev_rptr) <= 1), 32'd1);
        prev_rptr = rptr;
    endtask

    task automatic step();
        bit acc;
        acc = rinc && !m_empty;
        if (rinc && m_empty) m_under = 1;
        else if (underflow_clr) m_under = 0;
        if (acc) begin
            exp_q.push_back(m_fifo.pop_front());
            m_rcnt++;
        end
        m_level  = m_wq2 - m_rcnt;
        m_empty  = (m_level == 0);
        m_aempty = (m_level <= AEL);
        m_wq2    = m_wq1;
        m_wq1    = m_wcnt;
        @(posedge rclk);
        #1;
        check_status();
        rinc = 0;
        underflow_clr = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_aempty", 32'(aempty), 32'd1);
        chk("rst_rlevel", 32'(rlevel), 32'd0);
        chk("rst_rptr", 32'(rptr), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
    endtask

    initial begin
        rst_n = 0; rinc = 0; wptr = '0; underflow_clr = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        model_reset();
        #12;
        check_reset_outputs();
        rst_n = 1;
        @(posedge rclk); #1;

        // Empty read sets underflow; clear drops it; clear with an empty read keeps it.
        step();
        rinc = 1; step();
        underflow_clr = 1; step();
        rinc = 1; underflow_clr = 1; step();
        underflow_clr = 1; step();

        // Three words arrive at once, then are drained back-to-back.
        do_write(3);
        repeat (3) step();
        repeat (4) begin rinc = 1; step(); end

        // Full FIFO then drain, with an extra read attempted after the last word.
        do_write(DEPTH);
        repeat (3) step();
        repeat (DEPTH + 1) begin rinc = 1; step(); end
        underflow_clr = 1; step();

        // Concurrent write and read at a steady level.
        do_write(2);
        repeat (3) step();
        repeat (6) begin rinc = 1; do_write(1); step(); end
        repeat (4) begin rinc = 1; step(); end

        // Random traffic across several pointer wraps.
        for (int c = 0; c < 400; c++) begin
            rinc = ($urandom_range(0, 2) != 0);
            underflow_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) != 0) do_write($urandom_range(1, 2));
            step();
        end

        // Asynchronous reset in the middle of a burst.
        do_write(5);
        repeat (3) step();
        rinc = 1; step();
        rinc = 1; step();
        @(negedge rclk);
        #2;
        rst_n = 0;
        #1;
        check_reset_outputs();
        model_reset();
        wptr = '0; rinc = 0;
        @(posedge rclk);
        #3;
        rst_n = 1;
        @(posedge rclk); #1;
        prev_rptr = rptr;
        repeat (2) begin rinc = 1; step(); end
        do_write(4);
        repeat (3) step();
        repeat (5) begin rinc = 1; step(); end

        repeat (3) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
